// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared snake geometry, direction codes, food FSM states and wall check
package snake_pkg;

   localparam int GRID_W  = 40;
   localparam int GRID_H  = 30;
   localparam int XW      = $clog2(GRID_W);
   localparam int YW      = $clog2(GRID_H);
   localparam int MAX_LEN = 64;

   typedef enum logic [1:0] {
      UP    = 2'd0,
      RIGHT = 2'd1,
      DOWN  = 2'd2,
      LEFT  = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRAW   = 2'd1,
      ST_SCAN   = 2'd2,
      ST_COMMIT = 2'd3
   } food_state_t;

   // Same rule the engine uses for a crash: the outer ring of cells is wall.
   function automatic logic in_playfield(input logic [XW-1:0] x, input logic [YW-1:0] y);
      return (x >= XW'(1)) && (x <= XW'(GRID_W - 2)) &&
             (y >= YW'(1)) && (y <= YW'(GRID_H - 2));
   endfunction

endpackage

// File: rtl/food_lfsr.sv
// rtl/food_lfsr.sv - free-running 16-bit Galois LFSR (mask 16'hB400) reloaded with SEED on reset
module food_lfsr #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] lfsr
);

   localparam logic [15:0] MASK = 16'hB400;

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   // right-shifting Galois step: feedback bit is the bit shifted out
   always_comb begin
      lfsr_d = {1'b0, lfsr_q[15:1]};
      if (lfsr_q[0]) begin
         lfsr_d = lfsr_d ^ MASK;
      end
   end

   // state register; advances every cycle outside reset
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign lfsr = lfsr_q;

endmodule

// File: rtl/food_spawner.sv
// rtl/food_spawner.sv - apple placer: draws LFSR cells, rejects walls and bodies, commits a free cell (FOOD_TIMEOUT_EN adds apple relocation after idle ticks)
module food_spawner
   import snake_pkg::*;
#(
   parameter int          MAX_TRIES     = 255,
   parameter logic [15:0] SEED          = 16'hACE1,
   parameter int          TIMEOUT_TICKS = 100
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  consume_i,
   input  logic                  game_over,
   input  logic                  game_tick,
   input  logic [XW*MAX_LEN-1:0] body1_x_flat,
   input  logic [XW*MAX_LEN-1:0] body1_y_flat,
   input  logic [XW*MAX_LEN-1:0] body2_x_flat,
   input  logic [XW*MAX_LEN-1:0] body2_y_flat,
   input  logic [15:0]           len_1,
   input  logic [15:0]           len_2,
   output logic [XW-1:0]         food_x,
   output logic [YW-1:0]         food_y,
   output logic                  food_valid,
   output logic                  busy,
   output logic                  place_err
);

   localparam int TW = $clog2(MAX_TRIES + 1);
   localparam int SW = $clog2(MAX_LEN);

   food_state_t   state_q, state_d;
   logic [XW-1:0] food_x_q, food_x_d, cand_x_q, cand_x_d, draw_x;
   logic [YW-1:0] food_y_q, food_y_d, cand_y_q, cand_y_d, draw_y;
   logic          food_valid_q, food_valid_d;
   logic          busy_q, busy_d;
   logic          place_err_q, place_err_d;
   logic          have_cand_q, have_cand_d;
   logic          fallback_q, fallback_d;
   logic [TW-1:0] try_cnt_q, try_cnt_d, try_inc;
   logic [SW-1:0] seg_q, seg_d;
   logic [15:0]   lfsr;
   logic          draw_ok, hit1, hit2, hit, start, timeout_hit;
   logic          unused_lfsr;

   food_lfsr #(.SEED(SEED)) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .lfsr (lfsr)
   );

   assign draw_x      = XW'(lfsr[5:0]);
   assign draw_y      = YW'(lfsr[12:8]);
   assign draw_ok     = in_playfield(draw_x, draw_y);
   assign try_inc     = try_cnt_q + TW'(1);
   assign unused_lfsr = ^{lfsr[15:13], lfsr[7:6]};

   // bodies are looked at live, one segment index per cycle
   assign hit1 = (16'(seg_q) < len_1) &&
                 (body1_x_flat[XW*int'(seg_q) +: XW] == cand_x_q) &&
                 (body1_y_flat[XW*int'(seg_q) +: XW] == XW'(cand_y_q));
   assign hit2 = (16'(seg_q) < len_2) &&
                 (body2_x_flat[XW*int'(seg_q) +: XW] == cand_x_q) &&
                 (body2_y_flat[XW*int'(seg_q) +: XW] == XW'(cand_y_q));
   assign hit  = hit1 || hit2;

   assign start = (state_q == ST_IDLE) && !game_over && (consume_i || timeout_hit);

`ifdef FOOD_TIMEOUT_EN
   logic [7:0] age_q, age_d;
   logic       age_en;

   assign age_en      = (state_q == ST_IDLE) && food_valid_q && !game_over;
   assign timeout_hit = age_en && game_tick && (age_q == 8'(TIMEOUT_TICKS - 1));

   // apple age in game ticks; restarts with every search
   always_comb begin
      age_d = age_q;
      if (start) begin
         age_d = '0;
      end else if (age_en && game_tick) begin
         age_d = age_q + 8'd1;
      end
   end

   // age register
   always_ff @(posedge clk) begin
      if (rst) begin
         age_q <= '0;
      end else begin
         age_q <= age_d;
      end
   end
`else
   logic unused_tick;

   assign timeout_hit = 1'b0;
   assign unused_tick = game_tick ^ (TIMEOUT_TICKS != 0);
`endif

   // search FSM: next state and all registered outputs
   always_comb begin
      state_d      = state_q;
      food_x_d     = food_x_q;
      food_y_d     = food_y_q;
      food_valid_d = food_valid_q;
      busy_d       = busy_q;
      place_err_d  = place_err_q;
      cand_x_d     = cand_x_q;
      cand_y_d     = cand_y_q;
      have_cand_d  = have_cand_q;
      fallback_d   = fallback_q;
      try_cnt_d    = try_cnt_q;
      seg_d        = seg_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               // (0,0) is wall, so no live head can collide with the hidden apple
               state_d      = ST_DRAW;
               food_valid_d = 1'b0;
               busy_d       = 1'b1;
               food_x_d     = '0;
               food_y_d     = '0;
               try_cnt_d    = '0;
               have_cand_d  = 1'b0;
               fallback_d   = 1'b0;
            end
         end
         ST_DRAW: begin
            try_cnt_d = try_inc;
            if (draw_ok) begin
               cand_x_d    = draw_x;
               cand_y_d    = draw_y;
               have_cand_d = 1'b1;
               seg_d       = '0;
               state_d     = ST_SCAN;
            end else if (try_inc == TW'(MAX_TRIES)) begin
               fallback_d = 1'b1;
               state_d    = ST_COMMIT;
               if (!have_cand_q) begin
                  cand_x_d = XW'(1);
                  cand_y_d = YW'(1);
               end
            end
         end
         ST_SCAN: begin
            if (hit) begin
               if (try_cnt_q == TW'(MAX_TRIES)) begin
                  fallback_d = 1'b1;
                  state_d    = ST_COMMIT;
               end else begin
                  state_d = ST_DRAW;
               end
            end else if (seg_q == SW'(MAX_LEN - 1)) begin
               state_d = ST_COMMIT;
            end else begin
               seg_d = seg_q + SW'(1);
            end
         end
         ST_COMMIT: begin
            food_x_d     = cand_x_q;
            food_y_d     = cand_y_q;
            food_valid_d = 1'b1;
            busy_d       = 1'b0;
            place_err_d  = place_err_q | fallback_q;
            state_d      = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // state and output registers; reset abandons any search immediately
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         food_x_q     <= XW'(GRID_W / 2);
         food_y_q     <= YW'(GRID_H / 2);
         food_valid_q <= 1'b1;
         busy_q       <= 1'b0;
         place_err_q  <= 1'b0;
         cand_x_q     <= '0;
         cand_y_q     <= '0;
         have_cand_q  <= 1'b0;
         fallback_q   <= 1'b0;
         try_cnt_q    <= '0;
         seg_q        <= '0;
      end else begin
         state_q      <= state_d;
         food_x_q     <= food_x_d;
         food_y_q     <= food_y_d;
         food_valid_q <= food_valid_d;
         busy_q       <= busy_d;
         place_err_q  <= place_err_d;
         cand_x_q     <= cand_x_d;
         cand_y_q     <= cand_y_d;
         have_cand_q  <= have_cand_d;
         fallback_q   <= fallback_d;
         try_cnt_q    <= try_cnt_d;
         seg_q        <= seg_d;
      end
   end

   assign food_x     = food_x_q;
   assign food_y     = food_y_q;
   assign food_valid = food_valid_q;
   assign busy       = busy_q;
   assign place_err  = place_err_q;

endmodule

// File: tb/tb_food_spawner.sv
// tb/tb_food_spawner.sv - scoreboard bench for food_spawner with an independent LFSR/search model
module tb_food_spawner;

   typedef struct {
      int x;
      int y;
      int err;
      int lat;
      int start;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         consume_i, game_over, game_tick;
   logic [383:0] body1_x_flat, body1_y_flat, body2_x_flat, body2_y_flat;
   logic [15:0]  len_1, len_2;
   logic [5:0]   food_x;
   logic [4:0]   food_y;
   logic         food_valid, busy, place_err;

   logic [5:0]   b1x [64];
   logic [5:0]   b1y [64];
   logic [5:0]   b2x [64];
   logic [5:0]   b2y [64];

   logic [15:0]  m_lfsr = 16'hACE1;
   logic [15:0]  m_prev = 16'hACE1;
   int           cyc = 0;
   int           n_checks = 0;
   int           n_fail = 0;
   bit           exp_perr = 1'b0;
   exp_t         sb [$];

   food_spawner dut (
      .clk          (clk),
      .rst          (rst),
      .consume_i    (consume_i),
      .game_over    (game_over),
      .game_tick    (game_tick),
      .body1_x_flat (body1_x_flat),
      .body1_y_flat (body1_y_flat),
      .body2_x_flat (body2_x_flat),
      .body2_y_flat (body2_y_flat),
      .len_1        (len_1),
      .len_2        (len_2),
      .food_x       (food_x),
      .food_y       (food_y),
      .food_valid   (food_valid),
      .busy         (busy),
      .place_err    (place_err)
   );

   always #5 clk = ~clk;

   always_comb begin
      for (int g = 0; g < 64; g++) begin
         body1_x_flat[6*g +: 6] = b1x[g];
         body1_y_flat[6*g +: 6] = b1y[g];
         body2_x_flat[6*g +: 6] = b2x[g];
         body2_y_flat[6*g +: 6] = b2y[g];
      end
   end

   function automatic logic [15:0] lstep(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   always @(posedge clk) begin
      m_lfsr <= rst ? 16'hACE1 : lstep(m_lfsr);
      m_prev <= m_lfsr;
      cyc    <= cyc + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic bit pf_ok(input int x, input int y);
      return x >= 1 && x <= 38 && y >= 1 && y <= 28;
   endfunction

   function automatic bit wall_ok(input logic [15:0] l);
      return pf_ok(int'(l[5:0]), int'(l[12:8]));
   endfunction

   function automatic int first_hit(input int cx, input int cy);
      for (int s = 0; s < 64; s++) begin
         if ((s < int'(len_1) && int'(b1x[s]) == cx && int'(b1y[s]) == cy) ||
             (s < int'(len_2) && int'(b2x[s]) == cx && int'(b2y[s]) == cy)) begin
            return s;
         end
      end
      return -1;
   endfunction

   // l0 is the LFSR value on the edge that samples consume_i; chase means every candidate is hit at segment 0
   function automatic exp_t predict(input logic [15:0] l0, input bit chase);
      exp_t        e;
      logic [15:0] l;
      int          tries, h, lx, ly;
      bit          have;
      l = l0; tries = 0; have = 0; lx = 0; ly = 0;
      e.x = 0; e.y = 0; e.err = 0; e.lat = 0; e.start = 0;
      for (int guard = 0; guard < 1000; guard++) begin
         l = lstep(l);
         e.lat++;
         tries++;
         if (wall_ok(l)) begin
            have = 1; lx = int'(l[5:0]); ly = int'(l[12:8]);
            h = chase ? 0 : first_hit(lx, ly);
            if (h < 0) begin
               e.x = lx; e.y = ly; e.lat += 64 + 1;
               return e;
            end
            for (int k = 0; k <= h; k++) l = lstep(l);
            e.lat += h + 1;
            if (tries == 255) begin
               e.x = lx; e.y = ly; e.err = 1; e.lat += 1;
               return e;
            end
         end else if (tries == 255) begin
            e.x = have ? lx : 1; e.y = have ? ly : 1; e.err = 1; e.lat += 1;
            return e;
         end
      end
      return e;
   endfunction

   task automatic set_default_bodies();
      for (int g = 0; g < 64; g++) begin
         b1x[g] = '0; b1y[g] = '0; b2x[g] = '0; b2y[g] = '0;
      end
      for (int g = 0; g < 3; g++) begin
         b1x[g] = 6'(10 - g); b1y[g] = 6'd15;
         b2x[g] = 6'(30 + g); b2y[g] = 6'd15;
      end
      len_1 = 16'd3;
      len_2 = 16'd3;
   endtask

   // called at a negedge; the next posedge samples consume_i
   task automatic start_search(input bit chase);
      exp_t e;
      e = predict(m_lfsr, chase);
      e.err   = (e.err != 0 || exp_perr) ? 1 : 0;
      exp_perr = (e.err != 0);
      e.start = cyc + 1;
      sb.push_back(e);
      consume_i = 1'b1;
      @(negedge clk);
      consume_i = 1'b0;
      check_eq("start_busy", 32'(busy), 32'd1);
      check_eq("start_valid", 32'(food_valid), 32'd0);
      check_eq("start_food_x", 32'(food_x), 32'd0);
      check_eq("start_food_y", 32'(food_y), 32'd0);
   endtask

   task automatic await_commit(input bit chase, input int consume_at, input int gover_at);
      exp_t e;
      bit   got;
      got = 1'b0;
      for (int i = 1; i <= 3000 && !got; i++) begin
         @(negedge clk);
         if (chase) begin
            for (int g = 0; g < 64; g++) begin
               b1x[g] = m_prev[5:0];
               b1y[g] = {1'b0, m_prev[12:8]};
            end
         end
         consume_i = (i == consume_at);
         if (i == gover_at) game_over = 1'b1;
         if (food_valid && sb.size() > 0) begin
            got = 1'b1;
            e = sb.pop_front();
            check_eq("commit_x", 32'(food_x), 32'(e.x));
            check_eq("commit_y", 32'(food_y), 32'(e.y));
            check_eq("commit_latency", 32'(cyc - e.start), 32'(e.lat));
            check_eq("commit_place_err", 32'(place_err), 32'(e.err));
            check_eq("commit_busy", 32'(busy), 32'd0);
         end
      end
      consume_i = 1'b0;
      if (!got) check_eq("commit_timeout", 32'(got), 32'd1);
   endtask

   initial begin
      int fx, fy, n;
      bit found, seen;
      rst = 1'b1; consume_i = 1'b0; game_over = 1'b0; game_tick = 1'b0;
      set_default_bodies();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_eq("reset_food_x", 32'(food_x), 32'd20);
      check_eq("reset_food_y", 32'(food_y), 32'd15);
      check_eq("reset_valid", 32'(food_valid), 32'd1);
      check_eq("reset_busy", 32'(busy), 32'd0);
      check_eq("reset_place_err", 32'(place_err), 32'd0);

      // plain search against the default bodies
      start_search(1'b0);
      await_commit(1'b0, -1, -1);
      check_eq("t1_in_playfield", 32'(pf_ok(int'(food_x), int'(food_y))), 32'd1);
      check_eq("t1_off_bodies", 32'(first_hit(int'(food_x), int'(food_y)) < 0), 32'd1);

      // wait for a moment where the first two draws are both wall cells
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         if (!wall_ok(lstep(m_lfsr)) && !wall_ok(lstep(lstep(m_lfsr)))) found = 1'b1;
         else @(negedge clk);
      end
      check_eq("t2_found_double_reject", 32'(found), 32'd1);
      start_search(1'b0);
      await_commit(1'b0, -1, -1);

      // consume while busy is dropped; game_over mid-search does not abort
      start_search(1'b0);
      await_commit(1'b0, 10, 20);
      repeat (3) @(negedge clk);
      check_eq("t3_no_queued_search", 32'(busy), 32'd0);
      fx = int'(food_x); fy = int'(food_y);
      consume_i = 1'b1;
      @(negedge clk);
      consume_i = 1'b0;
      check_eq("t3_gameover_busy", 32'(busy), 32'd0);
      check_eq("t3_gameover_valid", 32'(food_valid), 32'd1);
      check_eq("t3_gameover_food_x", 32'(food_x), 32'(fx));
      check_eq("t3_gameover_food_y", 32'(food_y), 32'(fy));
      game_over = 1'b0;
      @(negedge clk);

      // game ticks without consume
      fx = int'(food_x); fy = int'(food_y);
      seen = 1'b0; n = 0;
`ifdef FOOD_TIMEOUT_EN
      for (int i = 0; i < 250 && !seen; i++) begin
         game_tick = 1'b1;
         @(negedge clk);
         game_tick = 1'b0;
         n++;
         if (busy) seen = 1'b1;
         else @(negedge clk);
      end
      check_eq("t4_timeout_tick_count", 32'(n), 32'd100);
      for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
      check_eq("t4_timeout_done", 32'(busy), 32'd0);
`else
      for (int i = 0; i < 200; i++) begin
         game_tick = 1'b1;
         @(negedge clk);
         game_tick = 1'b0;
         if (busy) seen = 1'b1;
         @(negedge clk);
         if (busy) seen = 1'b1;
      end
      check_eq("t4_no_search", 32'(seen), 32'd0);
      check_eq("t4_food_x", 32'(food_x), 32'(fx));
      check_eq("t4_food_y", 32'(food_y), 32'(fy));
`endif

      // every candidate gets covered by body1 segment 0: tries run out
      len_1 = 16'd64;
      len_2 = 16'd0;
      start_search(1'b1);
      await_commit(1'b1, -1, -1);
      check_eq("t5_place_err_sticky", 32'(place_err), 32'd1);
      set_default_bodies();
      @(negedge clk);

      // reset in the middle of a scan
      start_search(1'b0);
      repeat (31) @(negedge clk);
      check_eq("t6_busy_before_rst", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      exp_perr = 1'b0;
      check_eq("t6_rst_food_x", 32'(food_x), 32'd20);
      check_eq("t6_rst_food_y", 32'(food_y), 32'd15);
      check_eq("t6_rst_valid", 32'(food_valid), 32'd1);
      check_eq("t6_rst_busy", 32'(busy), 32'd0);
      check_eq("t6_rst_place_err", 32'(place_err), 32'd0);

      // search right after reset restarts the LFSR from SEED
      start_search(1'b0);
      await_commit(1'b0, -1, -1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
